// File: rtl/l2_mem_responder.sv
// ============================================================================
// l2_mem_responder : L2-side responder serving 8-beat line reads and
//                    single-word write-throughs from a word-addressed SRAM.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int BURST_LEN   = 8,
    parameter int STALL_EVERY = 0,
    parameter int WR_TIMEOUT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_l2_mem_access_addr,
    input  logic        i_rd_en,
    input  logic        i_wr_req,
    input  logic        i_l2_mem_wr_en,
    input  logic [31:0] i_l2_mem_wr_data,
    output logic        o_l2_bus_arbiter_rd_granted,
    output logic        o_l2_bus_arbiter_wr_granted,
    output logic [31:0] o_l2_mem_rd_data,
    input  logic        i_ld_en,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_busy
);

    localparam int c_IDX_W   = $clog2(DEPTH_WORDS);
    localparam int c_BEAT_W  = (BURST_LEN   > 1) ? $clog2(BURST_LEN)   : 1;
    localparam int c_STALL_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam int c_TO_W    = (WR_TIMEOUT  > 1) ? $clog2(WR_TIMEOUT)  : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DONE = 3'd2,
        S_WR_GNT  = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic                  r_rd_gnt,    w_rd_gnt_nxt;
    logic                  r_wr_gnt,    w_wr_gnt_nxt;
    logic [c_BEAT_W-1:0]   r_beat_cnt,  w_beat_cnt_nxt;
    logic [c_STALL_W-1:0]  r_stall_cnt, w_stall_cnt_nxt;
    logic [c_TO_W-1:0]     r_to_cnt,    w_to_cnt_nxt;
    logic                  r_busy;
    logic [31:0]           r_rd_data;

    logic [31:0]           r_mem [DEPTH_WORDS];

    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_beat;
    logic                  w_mem_we;
    logic [c_IDX_W-1:0]    w_mem_waddr;
    logic [31:0]           w_mem_wdata;
    logic                  w_unused;

    assign w_idx    = i_l2_mem_access_addr[c_IDX_W-1:0];
    assign w_beat   = (r_state == S_RD) & i_rd_en & r_rd_gnt;
    // Address bits above the index are deliberately ignored.
    assign w_unused = ^{i_l2_mem_access_addr[31:c_IDX_W], i_ld_addr[31:c_IDX_W]};

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_gnt_nxt    = 1'b0;
        w_wr_gnt_nxt    = 1'b0;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_mem_we        = 1'b0;
        w_mem_waddr     = w_idx;
        w_mem_wdata     = i_l2_mem_wr_data;

        case (r_state)
            S_IDLE: begin
                w_beat_cnt_nxt  = '0;
                w_stall_cnt_nxt = '0;
                w_to_cnt_nxt    = '0;
                if (i_rd_en) begin
                    w_state_nxt  = S_RD;
                    w_rd_gnt_nxt = 1'b1;
                end else if (i_wr_req) begin
                    w_state_nxt  = S_WR_GNT;
                    w_wr_gnt_nxt = 1'b1;
                end
                if (i_ld_en) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = i_ld_addr[c_IDX_W-1:0];
                    w_mem_wdata = i_ld_data;
                end
            end

            S_RD: begin
                if (!i_rd_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_beat) begin
                    if (r_beat_cnt == c_BEAT_W'(BURST_LEN - 1)) begin
                        w_state_nxt = S_RD_DONE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_BEAT_W'(1);
                        // Final beat takes priority over a stall, so no trailing gap.
                        if ((STALL_EVERY > 0) &&
                            (r_stall_cnt == c_STALL_W'(STALL_EVERY - 1))) begin
                            w_stall_cnt_nxt = '0;
                        end else begin
                            w_stall_cnt_nxt = r_stall_cnt + c_STALL_W'(1);
                            w_rd_gnt_nxt    = 1'b1;
                        end
                    end
                end else begin
                    w_rd_gnt_nxt = 1'b1;
                end
            end

            S_RD_DONE: begin
                if (!i_rd_en) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WR_GNT: begin
                w_state_nxt  = S_WR_WAIT;
                w_to_cnt_nxt = '0;
            end

            S_WR_WAIT: begin
                if (i_l2_mem_wr_en) begin
                    w_mem_we    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_to_cnt == c_TO_W'(WR_TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd_gnt    <= 1'b0;
            r_wr_gnt    <= 1'b0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_to_cnt    <= '0;
            r_busy      <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_gnt    <= w_rd_gnt_nxt;
            r_wr_gnt    <= w_wr_gnt_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_beat) begin
                r_rd_data <= r_mem[w_idx];
            end
        end
    end

    // Writes are blocked during reset so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign o_l2_bus_arbiter_rd_granted = r_rd_gnt;
    assign o_l2_bus_arbiter_wr_granted = r_wr_gnt;
    assign o_l2_mem_rd_data            = r_rd_data;
    assign o_busy                      = r_busy;

endmodule

`default_nettype wire
